mem_ctrl_icache: RTL and testbench
==================================

Name: mem_ctrl_icache

Overview:
Parametrised successor to the single-port byte-RAM memory controller. Arbitrates the instruction-fetch (IF) and load/store (LS) requesters onto one 8-bit synchronous RAM port. Contains a parametrised direct-mapped instruction cache with store-invalidate and a flush input. Sits between the IF/MEM pipeline stages and the external RAM.

Parameters:
IDX_BITS, 7, cache index width; the cache has 2**IDX_BITS one-word lines.
ADDR_BITS, 17, number of significant address bits; tag = addr[ADDR_BITS-1 : IDX_BITS+2].
ICACHE_EN, 1, 0 means every fetch goes to RAM and no lines are ever filled.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  one-cycle pulse; invalidates all cache lines
if_req  in  1  level; fetch request, held until if_valid
if_addr  in  32  fetch address, word-aligned, stable while if_req
if_valid  out  1  one-cycle pulse; if_data is valid
if_data  out  32  fetched instruction
ls_req  in  1  level; load/store request, held until ls_valid
ls_we  in  1  1 = store, 0 = load
ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
ls_addr  in  32  size-aligned address
ls_wdata  in  32  store data, little-endian
ls_valid  out  1  one-cycle pulse; load data valid or store complete
ls_rdata  out  32  load data, zero-extended
ram_din  in  8  RAM read data; valid the cycle after ram_a is presented
ram_dout  out  8  RAM write data
ram_a  out  32  RAM byte address (registered)
ram_wr  out  1  RAM write enable (registered)

Behaviour:
- Reset: state IDLE; if_valid, ls_valid, ram_wr = 0; if_data, ls_rdata, ram_a, ram_dout = 0; all cache valid bits cleared. rst asserted mid-transfer aborts the transfer with no valid pulse.
- States: IDLE, IF_RD, LS_RD, LS_WR, DONE.
- IDLE arbitration: if ls_req and if_req are both high, LS wins. In IDLE, ram_wr = 0 and ram_a = 0.
- IF hit (ICACHE_EN = 1, line valid, tag equal): if_data = line word and if_valid = 1 in the next cycle. No RAM access. Stays in IDLE.
- IF miss, request sampled in cycle 0:
  - ram_a = A, A+1, A+2, A+3 in cycles 1 to 4.
  - Bytes arrive on ram_din in cycles 2 to 5 and are assembled little-endian.
  - if_valid pulses in cycle 6, and the line is written (tag, valid) in the same edge.
- LS load of n bytes (n = 1, 2 or 4): same timing as an IF miss. ls_valid is in cycle n+2; for a byte load, ls_valid is in cycle 3. Loads never fill or touch the cache.
- LS store of n bytes:
  - ram_wr = 1 with ram_a = A+k and ram_dout = ls_wdata[8k+7:8k] in cycles 1 to n.
  - ls_valid pulses in cycle n+1, with ram_wr = 0 in that cycle.
- Store-invalidate: when a store is accepted, if the line at index ls_addr[IDX_BITS+1:2] is valid and its tag matches, that line's valid bit is cleared.
- DONE: lasts exactly the valid-pulse cycle. Requests are ignored in that cycle, so a requester that drops req in the valid cycle is never double-served. The FSM returns to IDLE and arbitrates again in the following cycle.
- flush: clears all valid bits at the next edge.
  - flush coincident with a fill: the flush takes priority, so the line is not left valid.
  - flush coincident with a hit lookup: the hit still completes; the flush takes effect afterwards.
- Address width: ram_a increments use 32-bit arithmetic and wrap modulo 2^32. The cache ignores addr bits at ADDR_BITS and above.
- Unaligned LS and non-word-aligned IF addresses are unsupported; no check is made.

Decomposition:
- Shared package (mem_ctrl_pkg):
  - state enum;
  - size encodings SZ_B/SZ_H/SZ_W;
  - derived TAG_W = ADDR_BITS - IDX_BITS - 2;
  - function size_to_bytes.
- One sub-module, icache_dm:
  - tag/data array plus valid-bit vector;
  - ports: lookup (addr to hit, data), fill (we, addr, data), inv (addr), flush.
- FSM, byte counter and assembly register stay in mem_ctrl_icache.

Test Plan:
- Cold fetch from 0x100 with RAM bytes 0x13,0x05,0x10,0x00 → ram_a 0x100..0x103 in cycles 1–4; if_valid in cycle 6 with if_data = 0x00100513. A repeat fetch of 0x100 → if_valid 1 cycle after req, and ram_a stays 0.
- if_req and ls_req raised in the same cycle (load word 0x200) → LS served first (ls_valid in cycle 6), then IF starts in cycle 8. Exactly one pulse per requester.
- Store byte 0xAB to 0x102 after 0x100 is cached → ram_wr = 1 in cycle 1 with ram_a = 0x102, ls_valid in cycle 2. The next fetch of 0x100 misses and returns the updated word 0x00AB0513.
- Half-word load from 0x3000 holding 0xFE,0x80 → ls_rdata = 0x000080FE, ls_valid in cycle 4.
- Pulse flush, then fetch a previously cached address → miss, full 6-cycle latency.
- Assert rst in cycle 3 of a word store → no ls_valid; ram_wr = 0 and state IDLE after the edge; all outputs at their reset values.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-RAM controller with instruction cache.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR,
        DONE
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int IDX_BITS_DEF  = 7;
    localparam int ADDR_BITS_DEF = 17;
    localparam int TAG_W         = ADDR_BITS_DEF - IDX_BITS_DEF - 2;

    function automatic int tag_width(input int addr_bits, input int idx_bits);
        return addr_bits - idx_bits - 2;
    endfunction

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: tag/data arrays plus valid bits.
module icache_dm
    import mem_ctrl_pkg::*;
#(
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ADDR_BITS-3:0] lookup_addr,
    output logic                 hit,
    output logic [31:0]          data,
    input  logic                 fill_we,
    input  logic [ADDR_BITS-3:0] fill_addr,
    input  logic [31:0]          fill_data,
    input  logic                 inv,
    input  logic [ADDR_BITS-3:0] inv_addr
);

    localparam int TW    = tag_width(ADDR_BITS, IDX_BITS);
    localparam int LINES = 1 << IDX_BITS;

    logic [TW-1:0]       tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];
    logic [LINES-1:0]    valid;
    logic [IDX_BITS-1:0] l_idx;
    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] i_idx;

    assign l_idx = lookup_addr[IDX_BITS-1:0];
    assign f_idx = fill_addr[IDX_BITS-1:0];
    assign i_idx = inv_addr[IDX_BITS-1:0];

    assign hit  = valid[l_idx] && (tag_mem[l_idx] == lookup_addr[ADDR_BITS-3:IDX_BITS]);
    assign data = data_mem[l_idx];

    // Flush outranks a fill on the same edge, so a flushed fill never survives.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else begin
            if (fill_we) valid[f_idx] <= 1'b1;
            if (inv && valid[i_idx] && tag_mem[i_idx] == inv_addr[ADDR_BITS-3:IDX_BITS])
                valid[i_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[f_idx]  <= fill_addr[ADDR_BITS-3:IDX_BITS];
            data_mem[f_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/mem_ctrl_icache.sv
// Arbitrates instruction fetch and load/store onto one 8-bit synchronous RAM port,
// with a direct-mapped instruction cache in front of the fetch path.
module mem_ctrl_icache
    import mem_ctrl_pkg::*;
#(
    parameter int IDX_BITS  = IDX_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter bit ICACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    state_t               state;
    state_t               state_next;
    logic [2:0]           cnt;
    logic [2:0]           nbytes;
    logic [2:0]           byte_idx;
    logic [31:0]          asm_q;
    logic [31:0]          rd_word;
    logic [23:0]          wdata_q;
    logic [ADDR_BITS-3:0] fill_waddr;
    logic                 cache_hit;
    logic [31:0]          cache_data;
    logic                 hit;
    logic                 start_hit;
    logic                 start_miss;
    logic                 start_ld;
    logic                 start_st;
    logic                 rd_last;
    logic                 wr_last;
    logic                 more_addr;
    logic                 fill_we;

    icache_dm #(
        .IDX_BITS  (IDX_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_icache (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .lookup_addr (if_addr[ADDR_BITS-1:2]),
        .hit         (cache_hit),
        .data        (cache_data),
        .fill_we     (fill_we),
        .fill_addr   (fill_waddr),
        .fill_data   (rd_word),
        .inv         (start_st),
        .inv_addr    (ls_addr[ADDR_BITS-1:2])
    );

    assign hit       = ICACHE_EN && cache_hit;
    assign byte_idx  = cnt - 3'd1;
    assign rd_word   = asm_q | ({24'd0, ram_din} << {byte_idx[1:0], 3'b000});
    assign rd_last   = (cnt == nbytes);
    assign wr_last   = (cnt == nbytes - 3'd1);
    assign more_addr = ({1'b0, cnt} + 4'd1) < {1'b0, nbytes};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A cache hit answers from IDLE; the if_valid cycle is masked so a held request is not re-served.
    always_comb begin
        state_next = state;
        start_hit  = 1'b0;
        start_miss = 1'b0;
        start_ld   = 1'b0;
        start_st   = 1'b0;
        fill_we    = 1'b0;
        case (state)
            IDLE: begin
                if (!if_valid) begin
                    if (ls_req) begin
                        if (ls_we) begin
                            start_st   = 1'b1;
                            state_next = LS_WR;
                        end else begin
                            start_ld   = 1'b1;
                            state_next = LS_RD;
                        end
                    end else if (if_req) begin
                        if (hit) begin
                            start_hit = 1'b1;
                        end else begin
                            start_miss = 1'b1;
                            state_next = IF_RD;
                        end
                    end
                end
            end
            IF_RD: begin
                if (rd_last) begin
                    fill_we    = ICACHE_EN;
                    state_next = DONE;
                end
            end
            LS_RD: begin
                if (rd_last) state_next = DONE;
            end
            LS_WR: begin
                if (wr_last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid   <= 1'b0;
            if_data    <= '0;
            ls_valid   <= 1'b0;
            ls_rdata   <= '0;
            ram_a      <= '0;
            ram_wr     <= 1'b0;
            ram_dout   <= '0;
            cnt        <= '0;
            nbytes     <= '0;
            asm_q      <= '0;
            wdata_q    <= '0;
            fill_waddr <= '0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ram_a  <= '0;
                    ram_wr <= 1'b0;
                    cnt    <= '0;
                    asm_q  <= '0;
                    if (start_hit) begin
                        if_valid <= 1'b1;
                        if_data  <= cache_data;
                    end
                    if (start_miss) begin
                        ram_a      <= if_addr;
                        nbytes     <= 3'd4;
                        fill_waddr <= if_addr[ADDR_BITS-1:2];
                    end
                    if (start_ld) begin
                        ram_a  <= ls_addr;
                        nbytes <= size_to_bytes(ls_size);
                    end
                    if (start_st) begin
                        ram_a    <= ls_addr;
                        ram_wr   <= 1'b1;
                        ram_dout <= ls_wdata[7:0];
                        wdata_q  <= ls_wdata[31:8];
                        nbytes   <= size_to_bytes(ls_size);
                    end
                end
                IF_RD, LS_RD: begin
                    // Byte k arrives one cycle after address A+k was presented.
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd0) asm_q <= rd_word;
                    ram_a <= more_addr ? ram_a + 32'd1 : 32'd0;
                    if (rd_last) begin
                        if (state == IF_RD) begin
                            if_valid <= 1'b1;
                            if_data  <= rd_word;
                        end else begin
                            ls_valid <= 1'b1;
                            ls_rdata <= rd_word;
                        end
                    end
                end
                LS_WR: begin
                    cnt <= cnt + 3'd1;
                    if (wr_last) begin
                        ram_wr   <= 1'b0;
                        ram_a    <= '0;
                        ls_valid <= 1'b1;
                    end else begin
                        ram_a    <= ram_a + 32'd1;
                        ram_dout <= wdata_q[7:0];
                        wdata_q  <= {8'd0, wdata_q[23:8]};
                    end
                end
                default: begin
                    ram_a  <= '0;
                    ram_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_icache.sv
// Directed bench for mem_ctrl_icache: vector table plus hand-written arbitration,
// flush and mid-transfer reset sequences against a byte-RAM model.
module tb_mem_ctrl_icache;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_ctrl_icache #(
        .IDX_BITS  (7),
        .ADDR_BITS (17),
        .ICACHE_EN (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_valid (ls_valid),
        .ls_rdata (ls_rdata),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_a    (ram_a),
        .ram_wr   (ram_wr)
    );

    // Byte RAM model: one-cycle read latency, write on ram_wr.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_a[15:0]] <= ram_dout;
        ram_din <= mem[ram_a[15:0]];
    end

    logic [31:0] ra_tr [0:15];
    logic        wr_tr [0:15];
    logic [7:0]  do_tr [0:15];

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          n_ram;
    } vec_t;

    vec_t vecs [20];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void check_reset_state(input string tag);
        check({tag, ".if_valid"}, 32'(if_valid), 32'd0);
        check({tag, ".ls_valid"}, 32'(ls_valid), 32'd0);
        check({tag, ".ram_wr"},   32'(ram_wr),   32'd0);
        check({tag, ".if_data"},  if_data,       32'd0);
        check({tag, ".ls_rdata"}, ls_rdata,      32'd0);
        check({tag, ".ram_a"},    ram_a,         32'd0);
        check({tag, ".ram_dout"}, 32'(ram_dout), 32'd0);
        check({tag, ".state"},    32'(dut.state), 32'(IDLE));
    endfunction

    // Request raised in cycle 0; requester drops req one edge after its valid pulse.
    task automatic run_txn(input bit is_if, input bit we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd, input int flush_cyc,
                           output int lat, output logic [31:0] data, output int pulses, output int other);
        bit drop;
        lat = -1; data = '0; pulses = 0; other = 0;
        @(posedge clk); #1;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wd;
        end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            flush = (cyc == flush_cyc);
            ra_tr[cyc] = ram_a; wr_tr[cyc] = ram_wr; do_tr[cyc] = ram_dout;
            drop = 1'b0;
            if (is_if ? if_valid : ls_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc;
                    data = is_if ? if_data : ls_rdata;
                end
                drop = 1'b1;
            end
            if (is_if ? ls_valid : if_valid) other++;
            @(posedge clk); #1;
            if (drop) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
        end
        flush = 1'b0;
    endtask

    task automatic fetch_check(input string name, input logic [31:0] addr, input int flush_cyc,
                               input logic [31:0] exp_data, input int exp_lat);
        int lat, pulses, other;
        logic [31:0] data;
        run_txn(1'b1, 1'b0, SZ_W, addr, 32'd0, flush_cyc, lat, data, pulses, other);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".data"}, data, exp_data);
        check({name, ".pulses"}, 32'(pulses), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses, other;
        logic [31:0] data;
        int ls_lat, if_lat, ls_p, if_p, ls_cnt;
        logic [31:0] ls_d, if_d, ra8;
        bit drop_ls, drop_if;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        {mem[16'h100], mem[16'h101], mem[16'h102], mem[16'h103]} = {8'h13, 8'h05, 8'h10, 8'h00};
        {mem[16'h200], mem[16'h201], mem[16'h202], mem[16'h203]} = {8'h11, 8'h22, 8'h33, 8'h44};
        {mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]} = {8'h78, 8'h56, 8'h34, 8'h12};
        {mem[16'h704], mem[16'h705], mem[16'h706], mem[16'h707]} = {8'h01, 8'h02, 8'h03, 8'h04};
        {mem[16'h3000], mem[16'h3001]} = {8'hFE, 8'h80};

        //           is_if we  size  addr          wdata         exp_data      lat n_ram
        vecs[0]  = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00100513, 6, 4};
        vecs[1]  = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00100513, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, SZ_W, 32'h200,   32'h0,        32'h44332211, 6, 4};
        vecs[3]  = '{1'b0, 1'b0, SZ_H, 32'h3000,  32'h0,        32'h000080FE, 4, 2};
        vecs[4]  = '{1'b0, 1'b0, SZ_B, 32'h3001,  32'h0,        32'h00000080, 3, 1};
        vecs[5]  = '{1'b0, 1'b1, SZ_B, 32'h102,   32'h000000AB, 32'h0,        2, 1};
        vecs[6]  = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00AB0513, 6, 4};
        vecs[7]  = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00AB0513, 1, 0};
        vecs[8]  = '{1'b0, 1'b1, SZ_W, 32'h540,   32'hDEADBEEF, 32'h0,        5, 4};
        vecs[9]  = '{1'b0, 1'b0, SZ_W, 32'h540,   32'h0,        32'hDEADBEEF, 6, 4};
        vecs[10] = '{1'b0, 1'b1, SZ_H, 32'h600,   32'h1234CAFE, 32'h0,        3, 2};
        vecs[11] = '{1'b0, 1'b0, SZ_W, 32'h600,   32'h0,        32'h0000CAFE, 6, 4};
        vecs[12] = '{1'b0, 1'b0, 2'd3, 32'h540,   32'h0,        32'hDEADBEEF, 6, 4};
        vecs[13] = '{1'b1, 1'b0, SZ_W, 32'h540,   32'h0,        32'hDEADBEEF, 6, 4};
        vecs[14] = '{1'b1, 1'b0, SZ_W, 32'h20540, 32'h0,        32'hDEADBEEF, 1, 0};
        vecs[15] = '{1'b1, 1'b0, SZ_W, 32'h300,   32'h0,        32'h12345678, 6, 4};
        vecs[16] = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00AB0513, 6, 4};
        vecs[17] = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00AB0513, 1, 0};
        vecs[18] = '{1'b0, 1'b1, SZ_B, 32'h302,   32'h00000099, 32'h0,        2, 1};
        vecs[19] = '{1'b1, 1'b0, SZ_W, 32'h100,   32'h0,        32'h00AB0513, 1, 0};

        rst = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i].is_if, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, -1,
                    lat, data, pulses, other);
            check($sformatf("v%0d.lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d.pulses", i), 32'(pulses), 32'd1);
            check($sformatf("v%0d.other_valid", i), 32'(other), 32'd0);
            if (!vecs[i].we) check($sformatf("v%0d.data", i), data, vecs[i].exp_data);
            if (vecs[i].n_ram == 0) begin
                check($sformatf("v%0d.hit_ram_a", i), ra_tr[1], 32'd0);
                check($sformatf("v%0d.hit_ram_wr", i), 32'(wr_tr[1]), 32'd0);
            end else begin
                for (int k = 0; k < vecs[i].n_ram; k++) begin
                    check($sformatf("v%0d.ram_a[c%0d]", i, k + 1), ra_tr[k + 1], vecs[i].addr + 32'(k));
                    check($sformatf("v%0d.ram_wr[c%0d]", i, k + 1), 32'(wr_tr[k + 1]), 32'(vecs[i].we));
                    if (vecs[i].we)
                        check($sformatf("v%0d.ram_dout[c%0d]", i, k + 1), 32'(do_tr[k + 1]),
                              (vecs[i].wdata >> (8 * k)) & 32'hFF);
                end
            end
            if (vecs[i].we && lat >= 0 && lat < 12)
                check($sformatf("v%0d.ram_wr_at_valid", i), 32'(wr_tr[lat]), 32'd0);
        end

        // Simultaneous requests: LS load first, fetch starts once DONE has passed.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SZ_W; ls_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h704;
        ls_lat = -1; if_lat = -1; ls_p = 0; if_p = 0; ls_d = '0; if_d = '0; ra8 = '0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            if (cyc == 8) ra8 = ram_a;
            drop_ls = 1'b0; drop_if = 1'b0;
            if (ls_valid) begin
                ls_p++;
                if (ls_lat < 0) begin ls_lat = cyc; ls_d = ls_rdata; end
                drop_ls = 1'b1;
            end
            if (if_valid) begin
                if_p++;
                if (if_lat < 0) begin if_lat = cyc; if_d = if_data; end
                drop_if = 1'b1;
            end
            @(posedge clk); #1;
            if (drop_ls) ls_req = 1'b0;
            if (drop_if) if_req = 1'b0;
        end
        check("arb.ls_lat", 32'(ls_lat), 32'd6);
        check("arb.ls_data", ls_d, 32'h44332211);
        check("arb.ls_pulses", 32'(ls_p), 32'd1);
        check("arb.if_ram_a_c8", ra8, 32'h704);
        check("arb.if_lat", 32'(if_lat), 32'd13);
        check("arb.if_data", if_d, 32'h04030201);
        check("arb.if_pulses", 32'(if_p), 32'd1);

        // Standalone flush, then flush coincident with a hit and with a fill.
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        fetch_check("flush.refetch", 32'h100, -1, 32'h00AB0513, 6);
        fetch_check("flush_hit.hit", 32'h100, 0, 32'h00AB0513, 1);
        fetch_check("flush_hit.after", 32'h100, -1, 32'h00AB0513, 6);
        fetch_check("flush_fill.fill", 32'h540, 5, 32'hDEADBEEF, 6);
        fetch_check("flush_fill.after", 32'h540, -1, 32'hDEADBEEF, 6);
        fetch_check("flush_fill.hit", 32'h540, -1, 32'hDEADBEEF, 1);

        // Reset in cycle 3 of a word store.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = SZ_W; ls_addr = 32'h800; ls_wdata = 32'h11223344;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        check("rst_mid.ram_wr_c3", 32'(ram_wr), 32'd1);
        check("rst_mid.ram_a_c3", ram_a, 32'h802);
        @(negedge clk);
        check_reset_state("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        ls_cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (ls_valid) ls_cnt++;
        end
        check("rst_mid.no_ls_valid", 32'(ls_cnt), 32'd0);
        fetch_check("rst_mid.cache_cleared", 32'h100, -1, 32'h00AB0513, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
